// File: rtl/issue_queue_if.sv
// issue_queue_if: fetch-side and decode-side handshakes plus occupancy for issue_queue
interface issue_queue_if #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int HLEN  = 5
);
  logic                    flush_i;
  logic                    fetch_valid_i;
  logic                    fetch_ready_o;
  logic [ILEN-1:0]         fetch_instr_i;
  logic [XLEN-1:0]         fetch_pred_pc_i;
  logic [XLEN-1:0]         fetch_pred_target_i;
  logic                    fetch_pred_taken_i;
  logic [HLEN-1:0]         fetch_pred_index_i;
  logic                    issue_valid_o;
  logic                    issue_ready_i;
  logic [ILEN-1:0]         issue_instr_o;
  logic [XLEN-1:0]         issue_pred_pc_o;
  logic [XLEN-1:0]         issue_pred_target_o;
  logic                    issue_pred_taken_o;
  logic [HLEN-1:0]         issue_pred_index_o;
  logic [$clog2(DEPTH):0]  count_o;
  modport slave (
    input  flush_i, fetch_valid_i, fetch_instr_i, fetch_pred_pc_i, fetch_pred_target_i,
           fetch_pred_taken_i, fetch_pred_index_i, issue_ready_i,
    output fetch_ready_o, issue_valid_o, issue_instr_o, issue_pred_pc_o, issue_pred_target_o,
           issue_pred_taken_o, issue_pred_index_o, count_o
  );
  modport master (
    output flush_i, fetch_valid_i, fetch_instr_i, fetch_pred_pc_i, fetch_pred_target_i,
           fetch_pred_taken_i, fetch_pred_index_i, issue_ready_i,
    input  fetch_ready_o, issue_valid_o, issue_instr_o, issue_pred_pc_o, issue_pred_target_o,
           issue_pred_taken_o, issue_pred_index_o, count_o
  );
endinterface

// File: rtl/issue_queue.sv
// issue_queue: in-order circular instruction buffer between fetch and decode with one-cycle flush
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int HLEN  = 5
) (
  input logic          clk_i,
  input logic          rst_i,
  issue_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ILEN + 2 * XLEN + 1 + HLEN;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic          push, pop;
  // Ready/valid depend only on registered occupancy, so a full queue never takes a push in its pop cycle
  assign q.fetch_ready_o = cnt_q != CW'(DEPTH);
  assign q.issue_valid_o = cnt_q != '0;
  assign q.count_o       = cnt_q;
  assign push            = q.fetch_valid_i & q.fetch_ready_o;
  assign pop             = q.issue_valid_o & q.issue_ready_i;
  assign {q.issue_instr_o, q.issue_pred_pc_o, q.issue_pred_target_o, q.issue_pred_taken_o,
          q.issue_pred_index_o} = q.issue_valid_o ? mem_q[rd_q] : '0;
  // Next pointers and occupancy; flush empties the queue and discards that cycle's push/pop
  always_comb begin
    rd_d  = q.flush_i ? '0 : rd_q + AW'(pop);
    wr_d  = q.flush_i ? '0 : wr_q + AW'(push);
    cnt_d = q.flush_i ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  // Pointer/occupancy registers; reset overrides everything
  always_ff @(posedge clk_i) begin
    rd_q  <= rst_i ? '0 : rd_d;
    wr_q  <= rst_i ? '0 : wr_d;
    cnt_q <= rst_i ? '0 : cnt_d;
  end
  // Entry storage is never cleared; a stray write during flush lands beyond the reset pointers
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= {q.fetch_instr_i, q.fetch_pred_pc_i, q.fetch_pred_target_i,
                              q.fetch_pred_taken_i, q.fetch_pred_index_i};
  end
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: scoreboard-driven checks of issue_queue ordering, full/empty, flush and reset
module tb_issue_queue;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    logic [4:0]  idx;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  ent_t sb[$];
  ent_t head, exp_e;
  issue_queue_if #(.DEPTH(8), .XLEN(32), .ILEN(32), .HLEN(5)) bus();
  issue_queue #(.DEPTH(8), .XLEN(32), .ILEN(32), .HLEN(5)) dut (.clk_i(clk), .rst_i(rst), .q(bus));
  always #5 clk = ~clk;
  assign head = {bus.issue_instr_o, bus.issue_pred_pc_o, bus.issue_pred_target_o,
                 bus.issue_pred_taken_o, bus.issue_pred_index_o};
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  function automatic ent_t mk(input logic [31:0] i, input logic [31:0] p, input logic [31:0] t,
                              input logic k, input logic [4:0] x);
    return '{instr: i, pc: p, tgt: t, tk: k, idx: x};
  endfunction
  task automatic drive(input logic v, input ent_t e);
    bus.fetch_valid_i = v;
    {bus.fetch_instr_i, bus.fetch_pred_pc_i, bus.fetch_pred_target_i,
     bus.fetch_pred_taken_i, bus.fetch_pred_index_i} = e;
  endtask
  task automatic tick();
    logic p, f;
    ent_t e;
    p = bus.fetch_valid_i & bus.fetch_ready_o;
    f = bus.flush_i | rst;
    e = {bus.fetch_instr_i, bus.fetch_pred_pc_i, bus.fetch_pred_target_i,
         bus.fetch_pred_taken_i, bus.fetch_pred_index_i};
    @(posedge clk);
    if (f) sb.delete();
    else if (p) sb.push_back(e);
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.flush_i = 1'b0;
    bus.issue_ready_i = 1'b0;
    drive(1'b0, '0);
    repeat (2) tick();
    total++; if (bus.count_o !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count_o); end
    total++; if (bus.issue_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.issue_valid_o); end
    total++; if (bus.fetch_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.fetch_ready_o); end
    total++; if (head !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", head); end
    rst = 1'b0;
  endtask
  task automatic test_fill_drain();
    bus.issue_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, mk(32'h13 + i, 32'h0, 32'h0, 1'b0, 5'd0));
      tick();
    end
    drive(1'b0, '0);
    total++; if (bus.count_o !== 4'd8) begin bad++; $display("FAIL fill_count got=%0d exp=8", bus.count_o); end
    total++; if (bus.fetch_ready_o !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", bus.fetch_ready_o); end
    bus.issue_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if (bus.issue_valid_o !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, bus.issue_valid_o); end
      exp_e = sb.pop_front();
      total++; if (head !== exp_e) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, head, exp_e); end
      total++; if (bus.issue_instr_o !== 32'h13 + i) begin bad++; $display("FAIL drain_instr[%0d] got=%h exp=%h", i, bus.issue_instr_o, 32'h13 + i); end
      tick();
    end
    total++; if (bus.issue_valid_o !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", bus.issue_valid_o); end
  endtask
  task automatic test_streaming();
    bus.issue_ready_i = 1'b1;
    drive(1'b1, mk(32'h100, 32'h1000, 32'h0, 1'b0, 5'd0));
    tick();
    for (int i = 1; i < 20; i++) begin
      total++; if (bus.count_o !== 4'd1) begin bad++; $display("FAIL stream_count[%0d] got=%0d exp=1", i, bus.count_o); end
      exp_e = sb.pop_front();
      total++; if (head !== exp_e) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, head, exp_e); end
      drive(1'b1, mk(32'h100 + i, 32'h1000 + 4 * i, 32'h0, 1'b0, 5'(i)));
      tick();
    end
    drive(1'b0, '0);
    total++; if (bus.issue_pred_pc_o !== 32'h1000 + 4 * 19) begin bad++; $display("FAIL stream_last_pc got=%h exp=%h", bus.issue_pred_pc_o, 32'h1000 + 4 * 19); end
    exp_e = sb.pop_front();
    total++; if (head !== exp_e) begin bad++; $display("FAIL stream_last got=%h exp=%h", head, exp_e); end
    tick();
    total++; if (bus.issue_valid_o !== 1'b0) begin bad++; $display("FAIL stream_empty got=%b exp=0", bus.issue_valid_o); end
  endtask
  task automatic test_full_pop();
    bus.issue_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, mk(32'h200 + i, 32'h0, 32'h0, 1'b0, 5'd0));
      tick();
    end
    drive(1'b1, mk(32'hdead, 32'h0, 32'h0, 1'b0, 5'd0));
    bus.issue_ready_i = 1'b1;
    total++; if (bus.fetch_ready_o !== 1'b0) begin bad++; $display("FAIL fullpop_ready got=%b exp=0", bus.fetch_ready_o); end
    exp_e = sb.pop_front();
    total++; if (head !== exp_e) begin bad++; $display("FAIL fullpop_head got=%h exp=%h", head, exp_e); end
    tick();
    drive(1'b0, '0);
    total++; if (bus.count_o !== 4'd7) begin bad++; $display("FAIL fullpop_count got=%0d exp=7", bus.count_o); end
    total++; if (bus.fetch_ready_o !== 1'b1) begin bad++; $display("FAIL fullpop_ready_next got=%b exp=1", bus.fetch_ready_o); end
    for (int i = 0; i < 7; i++) begin
      exp_e = sb.pop_front();
      total++; if (head !== exp_e) begin bad++; $display("FAIL fullpop_drain[%0d] got=%h exp=%h", i, head, exp_e); end
      tick();
    end
    total++; if (bus.issue_valid_o !== 1'b0) begin bad++; $display("FAIL fullpop_empty got=%b exp=0", bus.issue_valid_o); end
  endtask
  task automatic test_flush();
    bus.issue_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mk(32'h300 + i, 32'h0, 32'h0, 1'b0, 5'd0));
      tick();
    end
    total++; if (bus.count_o !== 4'd5) begin bad++; $display("FAIL flush_pre_count got=%0d exp=5", bus.count_o); end
    bus.flush_i = 1'b1;
    drive(1'b1, mk(32'hbad0, 32'h0, 32'h0, 1'b0, 5'd0));
    tick();
    bus.flush_i = 1'b0;
    drive(1'b0, '0);
    total++; if (bus.count_o !== 4'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", bus.count_o); end
    total++; if (bus.issue_valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", bus.issue_valid_o); end
    total++; if (head !== '0) begin bad++; $display("FAIL flush_data got=%h exp=0", head); end
    drive(1'b1, mk(32'h600d, 32'h0, 32'h0, 1'b0, 5'd0));
    tick();
    drive(1'b0, '0);
    total++; if (bus.count_o !== 4'd1) begin bad++; $display("FAIL flush_after_count got=%0d exp=1", bus.count_o); end
    total++; if (bus.issue_instr_o !== 32'h600d) begin bad++; $display("FAIL flush_after_instr got=%h exp=600d", bus.issue_instr_o); end
    exp_e = sb.pop_front();
    total++; if (head !== exp_e) begin bad++; $display("FAIL flush_after_head got=%h exp=%h", head, exp_e); end
    bus.issue_ready_i = 1'b1;
    tick();
    total++; if (bus.issue_valid_o !== 1'b0) begin bad++; $display("FAIL flush_after_empty got=%b exp=0", bus.issue_valid_o); end
  endtask
  task automatic test_metadata();
    bus.issue_ready_i = 1'b0;
    drive(1'b1, mk(32'h400, 32'h3000, 32'h2000, 1'b1, 5'h1f));
    tick();
    drive(1'b0, '0);
    total++; if (bus.issue_pred_taken_o !== 1'b1) begin bad++; $display("FAIL meta_taken got=%b exp=1", bus.issue_pred_taken_o); end
    total++; if (bus.issue_pred_target_o !== 32'h2000) begin bad++; $display("FAIL meta_target got=%h exp=2000", bus.issue_pred_target_o); end
    total++; if (bus.issue_pred_index_o !== 5'h1f) begin bad++; $display("FAIL meta_index got=%h exp=1f", bus.issue_pred_index_o); end
    total++; if (bus.issue_pred_pc_o !== 32'h3000) begin bad++; $display("FAIL meta_pc got=%h exp=3000", bus.issue_pred_pc_o); end
    exp_e = sb.pop_front();
    total++; if (head !== exp_e) begin bad++; $display("FAIL meta_head got=%h exp=%h", head, exp_e); end
    bus.issue_ready_i = 1'b1;
    tick();
  endtask
  task automatic test_reset_midstream();
    bus.issue_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(32'h500 + i, 32'h0, 32'h0, 1'b0, 5'd0));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, '0);
    total++; if (bus.count_o !== 4'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", bus.count_o); end
    total++; if (bus.issue_valid_o !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", bus.issue_valid_o); end
  endtask
  initial begin
    bus.flush_i = 1'b0;
    bus.issue_ready_i = 1'b0;
    drive(1'b0, '0);
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_streaming();
    test_full_pop();
    test_flush();
    test_metadata();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
